// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through capture FIFO for ALU results and
// status flags, with saturating overflow/drop counters and a sticky error
// flag for non-one-hot compare flags.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            y_in,
  input  logic                     parity_in,
  input  logic                     overflow_in,
  input  logic                     greater_in,
  input  logic                     is_eq_in,
  input  logic                     less_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_y,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     flag_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0]    mem_y [DEPTH];
  logic [4:0]       mem_f [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             flag_err_q, flag_err_d;

  logic             push, pop, cmp_onehot;

  // Status, handshake and FWFT head presentation (zeroed when empty).
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    in_ready  = rst_n & ~full;
    out_valid = ~empty;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_y     = empty ? '0 : mem_y[rd_ptr_q];
    out_flags = empty ? '0 : mem_f[rd_ptr_q];
    count     = count_q;
    ovf_cnt   = ovf_cnt_q;
    drop_cnt  = drop_cnt_q;
    flag_err  = flag_err_q;
  end

  // Compare flags must be exactly one of greater/equal/less.
  always_comb begin
    cmp_onehot = 1'b0;
    case ({greater_in, is_eq_in, less_in})
      3'b100, 3'b010, 3'b001: cmp_onehot = 1'b1;
      default:                cmp_onehot = 1'b0;
    endcase
  end

  // Next-state for pointers, occupancy and statistics.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_cnt_d  = ovf_cnt_q;
    drop_cnt_d = drop_cnt_q;
    flag_err_d = flag_err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (overflow_in && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      if (!cmp_onehot) flag_err_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (in_valid && !in_ready && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_cnt_q  <= '0;
      drop_cnt_q <= '0;
      flag_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_cnt_q  <= ovf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      flag_err_q <= flag_err_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr_q] <= y_in;
      mem_f[wr_ptr_q] <= {parity_in, overflow_in, greater_in, is_eq_in, less_in};
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: the stimulus process predicts
// acceptance from an occupancy model and queues expected words; a separate
// monitor compares the FIFO head whenever a pop is presented.
module tb_alu_result_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, parity_in, overflow_in, greater_in, is_eq_in, less_in;
  logic out_valid, out_ready, full, empty, flag_err;
  logic [DW-1:0] y_in, out_y;
  logic [4:0] out_flags;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] ovf_cnt, drop_cnt;

  alu_result_fifo #(.DEPTH(DEPTH), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .parity_in(parity_in), .overflow_in(overflow_in),
    .greater_in(greater_in), .is_eq_in(is_eq_in), .less_in(less_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_flags(out_flags), .count(count), .full(full), .empty(empty),
    .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [12:0] sb [$];
  int unsigned mcount, movf, mdrop;
  bit merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every presented pop must match the oldest outstanding word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("pop_without_expected", 32'(out_y), 32'hFFFF_FFFF);
      end else begin
        logic [12:0] e;
        e = sb.pop_front();
        chk("out_y", 32'(out_y), 32'(e[12:5]));
        chk("out_flags", 32'(out_flags), 32'(e[4:0]));
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1.
  task automatic step(input logic v, input logic [7:0] y, input logic [4:0] f,
                      input logic ordy, input logic rstn);
    bit acc, pp, bad;
    rst_n = rstn; in_valid = v; y_in = y; out_ready = ordy;
    {parity_in, overflow_in, greater_in, is_eq_in, less_in} = f;
    acc = rstn && v && (mcount < DEPTH);
    pp  = rstn && ordy && (mcount > 0);
    bad = ($countones(f[2:0]) != 1);
    if (acc) sb.push_back({y, f});
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(rstn && (mcount < DEPTH)));
    if (rstn) begin
      chk("count", 32'(count), mcount);
      chk("full", 32'(full), 32'(mcount == DEPTH));
      chk("empty", 32'(empty), 32'(mcount == 0));
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("ovf_cnt", 32'(ovf_cnt), movf);
      chk("drop_cnt", 32'(drop_cnt), mdrop);
      chk("flag_err", 32'(flag_err), 32'(merr));
      if (mcount == 0) begin
        chk("empty_out_y", 32'(out_y), 32'h0);
        chk("empty_out_flags", 32'(out_flags), 32'h0);
      end
    end
    @(posedge clk);
    if (!rstn) begin
      mcount = 0; movf = 0; mdrop = 0; merr = 0;
      sb.delete();
    end else begin
      if (acc) begin
        mcount++;
        if (f[3] && movf < SAT) movf++;
        if (bad) merr = 1;
      end
      if (v && !acc && mdrop < SAT) mdrop++;
      if (pp) mcount--;
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 8'h00, 5'b00010, ordy, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'hEE, 5'b00100, 1'b1, 1'b0);
  endtask

  function automatic logic [4:0] rand_flags(input bit allow_bad);
    logic [2:0] c;
    logic [1:0] po;
    po = 2'($urandom);
    if (allow_bad && ($urandom % 8 == 0)) c = 3'($urandom);
    else c = 3'(1 << ($urandom % 3));
    return {po, c};
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; y_in = 0;
    {parity_in, overflow_in, greater_in, is_eq_in, less_in} = '0;
    mcount = 0; movf = 0; mdrop = 0; merr = 0;
    @(posedge clk); #1;

    // Reset while in_valid is high.
    do_reset(2);
    idle(1'b0);

    // Single push, FWFT readout, then pop.
    step(1'b1, 8'h5A, 5'b10100, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Overfill: 0x01..0x06, two refused; drain in order.
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 5'b00010, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 5'b01001, 1'b0, 1'b1);
    step(1'b1, 8'h77, 5'b00100, 1'b1, 1'b1);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Streaming across pointer wrap, overflow on odd indices.
    do_reset(1);
    for (int i = 0; i < 20; i++)
      step(1'b1, 8'(i), {1'b0, 1'(i % 2), 3'b010}, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Overflow counter saturation.
    do_reset(1);
    for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 5'b01100, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Drop counter saturation while full.
    do_reset(1);
    for (int i = 0; i < 304; i++) step(1'b1, 8'(i), 5'b00001, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Illegal compare flags, then legal; sticky until reset.
    do_reset(1);
    step(1'b1, 8'hC3, 5'b11110, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 5'b00001, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    do_reset(1);
    idle(1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom % 100 == 0) do_reset(1);
      else step(1'($urandom % 4 != 0), 8'($urandom), rand_flags(1'b1),
                1'($urandom % 3 != 0), 1'b1);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream capture stage for the 8-bit ALU datapath.
- Registers each ALU result word y[7:0] together with its status flags (parity, overflow, greater, is_eq, less) into a small first-word-fall-through FIFO.
- Presents the buffered results to the consumer over a valid/ready handshake.
- Keeps saturating statistics counters (overflow events, dropped results) and a sticky flag-consistency error for the compare flags.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- DW, 8, result data width; matches ALU y width.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  FIFO can accept; combinational, equals !full, forced 0 while rst_n=0.
- y_in  input  DW  ALU result.
- parity_in  input  1  ALU parity flag.
- overflow_in  input  1  ALU overflow flag.
- greater_in  input  1  a>b.
- is_eq_in  input  1  a==b.
- less_in  input  1  a<b.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head.
- out_y  output  DW  head result.
- out_flags  output  5  head flags {parity,overflow,greater,is_eq,less}.
- count  output  clog2(DEPTH)+1  current occupancy.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- ovf_cnt  output  CNT_W  accepted results with overflow_in=1.
- drop_cnt  output  CNT_W  cycles with in_valid=1 and in_ready=0.
- flag_err  output  1  sticky compare-flag error.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - wr_ptr, rd_ptr and count return to 0; empty=1, full=0, out_valid=0.
  - out_y, out_flags, ovf_cnt, drop_cnt and flag_err return to 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries; the first cycle after reset behaves as empty.
- Push:
  - Occurs when in_valid && in_ready at a rising edge.
  - Writes {y_in, flags} at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Pop:
  - Occurs when out_valid && out_ready at a rising edge.
  - rd_ptr increments modulo DEPTH.
- FWFT output:
  - out_valid = !empty.
  - out_y/out_flags reflect the entry at rd_ptr combinationally from storage.
  - When empty, out_y and out_flags drive 0.
  - Latency: a push at edge N into an empty FIFO gives out_valid=1 from N+1. There is no same-cycle bypass.
- Occupancy:
  - count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop.
- Full:
  - in_ready=0; a push is refused even if a pop occurs in the same cycle.
  - The pop proceeds, and in_ready returns to 1 on the next cycle.
- Empty:
  - out_ready is ignored; no pointer movement.
- Drops:
  - Each cycle with in_valid=1 && in_ready=0 (including while full) increments drop_cnt.
  - drop_cnt saturates at 2^CNT_W-1. The rst_n=0 cycle does not count.
- Overflow statistics:
  - ovf_cnt increments on each accepted push with overflow_in=1.
  - It saturates at 2^CNT_W-1.
- Flag check:
  - On each accepted push, {greater_in,is_eq_in,less_in} must be exactly one-hot.
  - Otherwise flag_err sets on that edge and stays set until reset.
  - The entry is still stored unchanged.
- Pointers and count are registered; full/empty are derived from count.
- No other combinational path exists from in_* to out_*.

Test Plan:
1. Reset with rst_n=0 for 2 cycles while in_valid=1 -> out_valid=0, count=0, ovf_cnt=0, drop_cnt=0, flag_err=0, in_ready=0 during reset and 1 after.
2. Push y_in=0x5A with flags {1,0,1,0,0}, out_ready=0 -> next cycle out_valid=1, out_y=0x5A, out_flags=5'b10100, count=1. Raise out_ready -> following cycle empty=1, out_y=0x00.
3. Push 0x01..0x06 on consecutive cycles with out_ready=0 -> entries 0x01..0x04 accepted, full=1 after the 4th. Pushes of 0x05 and 0x06 are refused and drop_cnt=2. Draining yields 0x01,0x02,0x03,0x04 in order.
4. Full FIFO with simultaneous in_valid=1 and out_ready=1 -> pop occurs, push refused, count=3, drop_cnt+1; next cycle in_ready=1.
5. Streaming with in_valid=1 and out_ready=1 for 20 cycles, y_in=cycle index, overflow_in=1 on every odd index -> count steady at 1, outputs in order across pointer wrap, ovf_cnt=10. With CNT_W=8 and 300 overflow pushes, ovf_cnt=255.
6. Push with {greater,is_eq,less}=3'b110, then a legal push 3'b001 -> flag_err=1 after the first push and still 1 after the second. The stored flags read back 5'bxx110 (parity/overflow bits as driven). A later rst_n=0 clears flag_err.
